capsense_array: RTL and testbench

CAPSENSE_ARRAY -- requirements
Module: capsense_array

---
 rtl/capsense_array.sv | 217 +++++++++++++++++++++
 tb/tb_capsense_array.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capsense_array.sv
// capsense_array: time-multiplexed capacitive touch scanner.
// Each scan discharges every pad, releases them together and times how long
// each takes to be pulled high. A slow rise (large count) means extra
// capacitance, i.e. a finger. The raw result is debounced per channel and
// turned into level, press-pulse and toggle outputs.
//
// Ports
//   CLK, RESET        clock, synchronous active-high reset
//   ENABLE            start a scan (looked at only while idle)
//   PAD_IN[N_BTN]     raw pad levels, asynchronous
//   TOGGLE_EN[N_BTN]  per-channel 1 = toggle mode, 0 = momentary
//   PAD_OE[N_BTN]     1 = drive pad low, 0 = release pad
//   STATE[N_BTN]      debounced touched level
//   PRESS[N_BTN]      one-cycle pulse on debounced 0->1
//   TOGGLE[N_BTN]     toggle or momentary output per channel
//   ANY_PRESS         OR of PRESS
//   SCAN_DONE         one-cycle pulse when the outputs update
//   IDLE_TIMEOUT      high once TIMEOUT_SCANS press-free scans have elapsed

// Per-channel datapath: synchronizer, rise capture, debounce, outputs.
module capsense_chan #(
    parameter int CNT_W     = 8,
    parameter int THRESH    = 32,
    parameter int DEB_SCANS = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             arm_i,
    input  logic             meas_i,
    input  logic             eval_i,
    input  logic [CNT_W-1:0] m_i,
    input  logic             pad_i,
    input  logic             toggle_en_i,
    output logic             state_o,
    output logic             press_o,
    output logic             toggle_o
);
    // Counter only has to reach DEB_SCANS-1; the flip happens on the next hit.
    localparam int BW = (DEB_SCANS > 1) ? $clog2(DEB_SCANS) : 1;

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] rise_q, rise_d;
    logic             got_q, got_d;
    logic [BW-1:0]    deb_q, deb_d;
    logic             state_q, state_d;
    logic             press_q, press_d;
    logic             toggle_q, toggle_d;
    logic             raw, flip;

    // Arming preloads the saturated value, so a pad that never rises
    // reads as MEAS_MAX without extra logic.
    always_comb begin
        rise_d = rise_q;
        got_d  = got_q;
        if (arm_i) begin
            rise_d = '1;
            got_d  = 1'b0;
        end else if (meas_i && sync2_q && !got_q) begin
            rise_d = m_i;
            got_d  = 1'b1;
        end
    end

    always_comb begin
        raw      = (rise_q >= CNT_W'(THRESH));
        flip     = eval_i && (raw != state_q) && (deb_q == BW'(DEB_SCANS - 1));
        deb_d    = deb_q;
        if (eval_i)
            deb_d = ((raw == state_q) || flip) ? '0 : deb_q + 1'b1;
        state_d  = state_q ^ flip;
        press_d  = flip && !state_q;
        toggle_d = toggle_q;
        if (eval_i)
            toggle_d = toggle_en_i ? (toggle_q ^ press_d) : state_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            rise_q   <= '0;
            got_q    <= 1'b0;
            deb_q    <= '0;
            state_q  <= 1'b0;
            press_q  <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            sync1_q  <= pad_i;
            sync2_q  <= sync1_q;
            rise_q   <= rise_d;
            got_q    <= got_d;
            deb_q    <= deb_d;
            state_q  <= state_d;
            press_q  <= press_d;
            toggle_q <= toggle_d;
        end
    end

    assign state_o  = state_q;
    assign press_o  = press_q;
    assign toggle_o = toggle_q;
endmodule

module capsense_array #(
    parameter int N_BTN         = 4,
    parameter int DISCH_CYC     = 64,
    parameter int CNT_W         = 8,
    parameter int THRESH        = 32,
    parameter int DEB_SCANS     = 3,
    parameter int TIMEOUT_SCANS = 1000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [N_BTN-1:0] PAD_IN,
    input  logic [N_BTN-1:0] TOGGLE_EN,
    output logic [N_BTN-1:0] PAD_OE,
    output logic [N_BTN-1:0] STATE,
    output logic [N_BTN-1:0] PRESS,
    output logic [N_BTN-1:0] TOGGLE,
    output logic             ANY_PRESS,
    output logic             SCAN_DONE,
    output logic             IDLE_TIMEOUT
);
    localparam int MEAS_MAX = (1 << CNT_W) - 1;
    localparam int DW       = $clog2(DISCH_CYC + 1);
    // One counter serves both the discharge and measure phases.
    localparam int SW       = (DW > CNT_W) ? DW : CNT_W;
    localparam int TW       = $clog2(TIMEOUT_SCANS + 1);

    typedef enum logic [1:0] {S_IDLE, S_DISCH, S_MEAS, S_EVAL} state_t;

    state_t        st_q, st_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          done_q;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          arm, meas, eval_s;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            st_q  <= S_IDLE;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // Next state
    always_comb begin
        st_d = st_q;
        unique case (st_q)
            S_IDLE:  if (ENABLE) st_d = S_DISCH;
            S_DISCH: if (cnt_q == SW'(DISCH_CYC - 1)) st_d = S_MEAS;
            S_MEAS:  if (cnt_q == SW'(MEAS_MAX - 1)) st_d = S_EVAL;
            S_EVAL:  st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
        // Phase counter restarts at 0 on every state change.
        cnt_d = '0;
        if ((st_d == st_q) && ((st_q == S_DISCH) || (st_q == S_MEAS)))
            cnt_d = cnt_q + 1'b1;
    end

    // Outputs
    always_comb begin
        PAD_OE = {N_BTN{st_q != S_MEAS}};
        arm    = (st_q == S_DISCH);
        meas   = (st_q == S_MEAS);
        eval_s = (st_q == S_EVAL);
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        capsense_chan #(
            .CNT_W     (CNT_W),
            .THRESH    (THRESH),
            .DEB_SCANS (DEB_SCANS)
        ) u_chan (
            .CLK         (CLK),
            .RESET       (RESET),
            .arm_i       (arm),
            .meas_i      (meas),
            .eval_i      (eval_s),
            .m_i         (cnt_q[CNT_W-1:0]),
            .pad_i       (PAD_IN[g]),
            .toggle_en_i (TOGGLE_EN[g]),
            .state_o     (STATE[g]),
            .press_o     (PRESS[g]),
            .toggle_o    (TOGGLE[g])
        );
    end

    assign ANY_PRESS = |PRESS;

    // Press-free scan counter; a press in the same scan wins over the count.
    always_comb begin
        tmo_d = tmo_q;
        if (ANY_PRESS)
            tmo_d = '0;
        else if (SCAN_DONE && (tmo_q != TW'(TIMEOUT_SCANS)))
            tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            done_q <= 1'b0;
            tmo_q  <= '0;
        end else begin
            done_q <= eval_s;
            tmo_q  <= tmo_d;
        end
    end

    assign SCAN_DONE    = done_q;
    assign IDLE_TIMEOUT = (tmo_q == TW'(TIMEOUT_SCANS));
endmodule

// File: tb/tb_capsense_array.sv
// Testbench for capsense_array: pad model reacting to PAD_OE, per-scan
// reference model of the debounce / toggle / timeout behaviour.
module tb_capsense_array;
    localparam int NB = 4, DC = 4, CW = 4, TH = 8, DS = 2, TO = 3;
    localparam int MEAS_MAX = 15;
    localparam int PERIOD   = 1 + DC + MEAS_MAX + 1;

    logic          CLK = 1'b0, RESET = 1'b1, ENABLE = 1'b0;
    logic [NB-1:0] PAD_IN = '0, TOGGLE_EN = '0;
    logic [NB-1:0] PAD_OE, STATE, PRESS, TOGGLE;
    logic          ANY_PRESS, SCAN_DONE, IDLE_TIMEOUT;

    capsense_array #(
        .N_BTN(NB), .DISCH_CYC(DC), .CNT_W(CW), .THRESH(TH),
        .DEB_SCANS(DS), .TIMEOUT_SCANS(TO)
    ) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .PAD_IN(PAD_IN),
        .TOGGLE_EN(TOGGLE_EN), .PAD_OE(PAD_OE), .STATE(STATE), .PRESS(PRESS),
        .TOGGLE(TOGGLE), .ANY_PRESS(ANY_PRESS), .SCAN_DONE(SCAN_DONE),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0, n_pass = 0;
    int cyc = 0, last_done = 0;
    int m_tb = -1;
    int rise_cyc [NB] = '{16, 16, 16, 16};

    always @(posedge CLK) cyc <= cyc + 1;

    // Pad model: held low while driven; once released, pad i reads high
    // from MEASURE cycle rise_cyc[i] onward (16 = never).
    always @(posedge CLK) begin
        #1;
        if (PAD_OE === '0) m_tb = m_tb + 1;
        else               m_tb = -1;
        for (int i = 0; i < NB; i++)
            PAD_IN[i] = (PAD_OE === '0) && (m_tb >= rise_cyc[i]);
    end

    // Reference model state
    logic [NB-1:0] md_st = '0, md_tog = '0;
    int            md_deb [NB] = '{0, 0, 0, 0};
    int            md_idle = 0;
    logic [NB-1:0] exp_press;
    logic          exp_any, exp_to_now, exp_to_next;

    // Observations
    logic [NB-1:0] obs_state, obs_press, obs_tog;
    logic          obs_any, obs_to_now, obs_done_next, obs_any_next, obs_to_next;
    int            obs_gap;

    task automatic model_reset();
        md_st = '0; md_tog = '0; md_idle = 0;
        for (int i = 0; i < NB; i++) md_deb[i] = 0;
    endtask

    // Runs one scan with the given pad rise cycles, captures outputs on the
    // SCAN_DONE cycle and the one after, and advances the reference model.
    task automatic run_scan(input int r0, input int r1, input int r2, input int r3);
        int  rr [NB];
        int  rise;
        bit  raw, seen;
        rr = '{r0, r1, r2, r3};
        rise_cyc = rr;
        seen = 1'b0;
        for (int k = 0; k < 80 && !seen; k++) begin
            @(negedge CLK);
            if (SCAN_DONE === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL scan_wait: SCAN_DONE not seen within 80 cycles");
        else       n_pass++;
        obs_state = STATE; obs_press = PRESS; obs_tog = TOGGLE;
        obs_any = ANY_PRESS; obs_to_now = IDLE_TIMEOUT;
        obs_gap = cyc - last_done;
        last_done = cyc;
        exp_to_now = (md_idle == TO);
        exp_press = '0;
        for (int i = 0; i < NB; i++) begin
            rise = (rr[i] + 2 > MEAS_MAX) ? MEAS_MAX : rr[i] + 2;
            raw  = (rise >= TH);
            if (raw != md_st[i]) begin
                md_deb[i]++;
                if (md_deb[i] == DS) begin
                    md_st[i] = raw;
                    md_deb[i] = 0;
                    exp_press[i] = raw;
                end
            end else begin
                md_deb[i] = 0;
            end
            md_tog[i] = TOGGLE_EN[i] ? (md_tog[i] ^ exp_press[i]) : md_st[i];
        end
        exp_any = |exp_press;
        md_idle = exp_any ? 0 : ((md_idle < TO) ? md_idle + 1 : TO);
        exp_to_next = (md_idle == TO);
        @(negedge CLK);
        obs_done_next = SCAN_DONE; obs_any_next = ANY_PRESS; obs_to_next = IDLE_TIMEOUT;
    endtask

    task automatic wait_meas(input int target, input string tag);
        bit hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge CLK);
            if (PAD_OE === '0 && m_tb == target) hit = 1'b1;
        end
        n_checks++;
        if (!hit) $display("FAIL %s: MEASURE cycle %0d not reached in 100 cycles", tag, target);
        else      n_pass++;
    endtask

    task automatic test_reset();
        RESET = 1'b1; ENABLE = 1'b0; TOGGLE_EN = '0;
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({STATE, PRESS, TOGGLE, ANY_PRESS, SCAN_DONE, IDLE_TIMEOUT} !== '0)
            $display("FAIL reset_outputs: got %b want all 0",
                     {STATE, PRESS, TOGGLE, ANY_PRESS, SCAN_DONE, IDLE_TIMEOUT});
        else n_pass++;
        n_checks++;
        if (PAD_OE !== 4'b1111) $display("FAIL reset_pad_oe: got %b want 1111", PAD_OE);
        else n_pass++;
        model_reset();
        RESET = 1'b0; ENABLE = 1'b1;
        last_done = cyc;
    endtask

    // No touches: fixed scan period, no presses, timeout after the 3rd scan.
    task automatic test_no_touch_timeout();
        for (int s = 1; s <= 4; s++) begin
            run_scan(1, 1, 1, 1);
            n_checks++;
            if (obs_gap != PERIOD) $display("FAIL notouch_period: scan %0d gap %0d want %0d", s, obs_gap, PERIOD);
            else n_pass++;
            n_checks++;
            if (obs_state !== 4'b0000 || obs_press !== 4'b0000 || obs_any !== 1'b0)
                $display("FAIL notouch_out: scan %0d state %b press %b any %b want 0", s, obs_state, obs_press, obs_any);
            else n_pass++;
            n_checks++;
            if (obs_done_next !== 1'b0) $display("FAIL done_pulse: SCAN_DONE %b a cycle later want 0", obs_done_next);
            else n_pass++;
            n_checks++;
            if (obs_to_next !== (s >= TO)) $display("FAIL idle_timeout: scan %0d got %b want %b", s, obs_to_next, s >= TO);
            else n_pass++;
        end
    endtask

    // Pad 2 slow rise: one scan alone does nothing, two in a row press.
    task automatic test_debounce();
        int tbl [6][NB] = '{'{1,1,9,1}, '{1,1,1,1}, '{1,1,9,1}, '{1,1,9,1}, '{1,1,1,1}, '{1,1,1,1}};
        logic [NB-1:0] want_st [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
        logic [NB-1:0] want_pr [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
        for (int s = 0; s < 6; s++) begin
            run_scan(tbl[s][0], tbl[s][1], tbl[s][2], tbl[s][3]);
            n_checks++;
            if (obs_state !== want_st[s] || obs_press !== want_pr[s])
                $display("FAIL debounce: scan %0d state %b press %b want %b %b", s, obs_state, obs_press, want_st[s], want_pr[s]);
            else n_pass++;
            n_checks++;
            if (obs_any !== (want_pr[s] != 0)) $display("FAIL debounce_any: scan %0d got %b", s, obs_any);
            else n_pass++;
            n_checks++;
            if (obs_to_now !== exp_to_now || obs_to_next !== exp_to_next)
                $display("FAIL debounce_timeout: scan %0d got %b%b want %b%b", s, obs_to_now, obs_to_next, exp_to_now, exp_to_next);
            else n_pass++;
        end
    endtask

    // Pads 0 and 3 never rise: simultaneous press; toggle mode on those pads.
    task automatic test_toggle();
        int tbl [6][NB] = '{'{16,1,1,16}, '{16,1,1,16}, '{1,1,1,1}, '{1,1,1,1}, '{16,1,1,16}, '{16,1,1,16}};
        logic [NB-1:0] want_pr  [6] = '{4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1001};
        logic [NB-1:0] want_tog [6] = '{4'b0000, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0000};
        TOGGLE_EN = 4'b1001;
        for (int s = 0; s < 6; s++) begin
            run_scan(tbl[s][0], tbl[s][1], tbl[s][2], tbl[s][3]);
            n_checks++;
            if (obs_press !== want_pr[s] || obs_tog !== want_tog[s])
                $display("FAIL toggle: scan %0d press %b toggle %b want %b %b", s, obs_press, obs_tog, want_pr[s], want_tog[s]);
            else n_pass++;
            n_checks++;
            if (obs_any !== exp_any || obs_any_next !== 1'b0)
                $display("FAIL toggle_any: scan %0d any %b next %b want %b 0", s, obs_any, obs_any_next, exp_any);
            else n_pass++;
            n_checks++;
            if (obs_state !== md_st) $display("FAIL toggle_state: scan %0d got %b want %b", s, obs_state, md_st);
            else n_pass++;
        end
        n_checks++;
        if (obs_to_next !== 1'b0) $display("FAIL timeout_clear: got %b want 0", obs_to_next);
        else n_pass++;
    endtask

    // Threshold boundary: RISE 8 touches, RISE 7 does not; late rises saturate.
    task automatic test_threshold();
        TOGGLE_EN = 4'b0000;
        for (int s = 0; s < 2; s++) begin
            run_scan(6, 5, 12, 13);
            n_checks++;
            if (obs_state !== md_st || obs_press !== exp_press || obs_tog !== md_tog)
                $display("FAIL threshold: scan %0d st %b pr %b tg %b want %b %b %b",
                         s, obs_state, obs_press, obs_tog, md_st, exp_press, md_tog);
            else n_pass++;
        end
        n_checks++;
        if (obs_state !== 4'b1101 || obs_press !== 4'b0100)
            $display("FAIL threshold_edge: state %b press %b want 1101 0100", obs_state, obs_press);
        else n_pass++;
    endtask

    // ENABLE dropped mid-measure: the scan finishes, then the block idles.
    task automatic test_enable_drop();
        bit bad = 1'b0;
        rise_cyc = '{0, 0, 0, 0};
        wait_meas(3, "enable_drop_wait");
        ENABLE = 1'b0;
        run_scan(0, 0, 0, 0);
        n_checks++;
        if (obs_state !== md_st || obs_press !== exp_press)
            $display("FAIL enable_drop_scan: state %b press %b want %b %b", obs_state, obs_press, md_st, exp_press);
        else n_pass++;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (SCAN_DONE !== 1'b0 || PAD_OE !== 4'b1111) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL enable_drop_idle: activity seen (done %b oe %b) want idle", SCAN_DONE, PAD_OE);
        else n_pass++;
        ENABLE = 1'b1;
        last_done = cyc;
        run_scan(1, 1, 1, 1);
        n_checks++;
        if (obs_gap != PERIOD) $display("FAIL enable_restart: gap %0d want %0d", obs_gap, PERIOD);
        else n_pass++;
    endtask

    // Reset in the middle of MEASURE clears everything; next scan is clean.
    task automatic test_reset_mid_scan();
        TOGGLE_EN = 4'b1111;
        run_scan(16, 16, 16, 16);
        run_scan(16, 16, 16, 16);
        n_checks++;
        if (obs_state !== 4'b1111) $display("FAIL pre_reset_state: got %b want 1111", obs_state);
        else n_pass++;
        rise_cyc = '{0, 0, 0, 0};
        wait_meas(7, "reset_wait");
        RESET = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({STATE, PRESS, TOGGLE, ANY_PRESS, SCAN_DONE, IDLE_TIMEOUT} !== '0 || PAD_OE !== 4'b1111)
            $display("FAIL mid_reset: outs %b oe %b want 0 and 1111",
                     {STATE, PRESS, TOGGLE, ANY_PRESS, SCAN_DONE, IDLE_TIMEOUT}, PAD_OE);
        else n_pass++;
        model_reset();
        RESET = 1'b0;
        last_done = cyc;
        run_scan(1, 1, 1, 1);
        n_checks++;
        if (obs_gap != PERIOD) $display("FAIL reset_restart: gap %0d want %0d", obs_gap, PERIOD);
        else n_pass++;
        n_checks++;
        if (obs_state !== 4'b0000 || obs_tog !== 4'b0000 || obs_press !== 4'b0000)
            $display("FAIL reset_restart_out: st %b tg %b pr %b want 0", obs_state, obs_tog, obs_press);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int s = 0; s < 40; s++) begin
            run_scan($urandom_range(0, 16), $urandom_range(0, 16), $urandom_range(0, 16), $urandom_range(0, 16));
            n_checks++;
            if (obs_state !== md_st || obs_press !== exp_press || obs_tog !== md_tog || obs_any !== exp_any)
                $display("FAIL random: scan %0d st %b pr %b tg %b any %b want %b %b %b %b",
                         s, obs_state, obs_press, obs_tog, obs_any, md_st, exp_press, md_tog, exp_any);
            else n_pass++;
            n_checks++;
            if (obs_to_now !== exp_to_now || obs_to_next !== exp_to_next || obs_gap != PERIOD)
                $display("FAIL random_timing: scan %0d to %b%b gap %0d want %b%b %0d",
                         s, obs_to_now, obs_to_next, obs_gap, exp_to_now, exp_to_next, PERIOD);
            else n_pass++;
            TOGGLE_EN = NB'($urandom_range(0, 15));
        end
    endtask

    initial begin
        test_reset();
        test_no_touch_timeout();
        test_debounce();
        test_toggle();
        test_threshold();
        test_enable_drop();
        test_reset_mid_scan();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
